// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S test-tone frame sequencer.
package i2s_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_SLOT_W   = 32;
    localparam int DEF_BCK_HALF = 2;
    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_PHASE_W  = 24;

    // Word-select polarity: low marks the left channel slot.
    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator that addresses the sine LUT once per stereo frame.
// On a step the LUT address is taken from the current phase and the tuning
// word is snapshotted; the increment is folded in on the following cycle,
// long before the next frame start needs the new phase.
module phase_acc import i2s_pkg::*; #(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               scki,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic [PHASE_W-1:0] tuning_word_i,
    output logic [ADDR_W-1:0]  lut_addr_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] tw_shadow_q, tw_shadow_d;
    logic [PHASE_W-1:0] phase_now;
    logic               add_q, add_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // Fold any pending increment, then clear or snapshot address and tuning word on a step
    always_comb begin
        phase_now   = add_q ? (phase_q + tw_shadow_q) : phase_q;
        phase_d     = phase_now;
        tw_shadow_d = tw_shadow_q;
        add_d       = 1'b0;
        addr_d      = addr_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (step_i) begin
            addr_d      = phase_now[PHASE_W-1 -: ADDR_W];
            tw_shadow_d = tuning_word_i;
            add_d       = 1'b1;
        end
    end

    // Accumulator, shadow and address registers
    always_ff @(posedge scki or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            tw_shadow_q <= '0;
            add_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            tw_shadow_q <= tw_shadow_d;
            add_q       <= add_d;
            addr_q      <= addr_d;
        end
    end

    assign lut_addr_o = addr_q;

endmodule

// File: rtl/i2s_tone_ctrl.sv
// I2S test-tone frame sequencer: bit/word clocks, per-frame LUT addressing,
// sample capture and MSB-first serialisation of the same sample into both slots.
module i2s_tone_ctrl import i2s_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCK_HALF = DEF_BCK_HALF,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PHASE_W  = DEF_PHASE_W
) (
    input  logic               scki,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [DATA_W-1:0]  sample_in,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic               bck,
    output logic               lrck,
    output logic               sdata,
    output logic               frame_strobe,
    output logic               busy
);

    localparam int DIV_W = $clog2(BCK_HALF);
    localparam int BIT_W = $clog2(SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W);

    state_t             state_q, state_d;
    logic               bck_q, bck_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               slot_q, slot_d;
    logic               lrck_q, lrck_d;
    logic               sdata_q, sdata_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               strobe_q, strobe_d;
    logic               cap_q, cap_d;
    logic               phase_step;
    logic               phase_clear;

    phase_acc #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W)
    ) u_phase_acc (
        .scki          (scki),
        .rst           (rst),
        .clear_i       (phase_clear),
        .step_i        (phase_step),
        .tuning_word_i (tuning_word),
        .lut_addr_o    (lut_addr)
    );

    // Next state: bit-clock divider, slot/bit sequencing, frame start and stop decision
    always_comb begin
        state_d     = state_q;
        bck_d       = bck_q;
        div_d       = div_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        strobe_d    = 1'b0;
        cap_d       = strobe_q;
        phase_step  = 1'b0;
        phase_clear = 1'b0;

        if (cap_q) begin
            hold_d = sample_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                bck_d   = 1'b0;
                lrck_d  = LRCK_RIGHT;
                sdata_d = 1'b0;
                if (en) begin
                    state_d     = ST_RUN;
                    bck_d       = 1'b1;
                    div_d       = '0;
                    bit_d       = '0;
                    slot_d      = 1'b0;
                    phase_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (!bck_q) begin
                        bck_d = 1'b1;
                    end else if (bit_q == '0 && !slot_q && !en) begin
                        state_d = ST_IDLE;
                        bck_d   = 1'b0;
                        lrck_d  = LRCK_RIGHT;
                        sdata_d = 1'b0;
                    end else begin
                        bck_d = 1'b0;
                        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_ONE;
                        if (bit_q == BIT_LAST) begin
                            slot_d = ~slot_q;
                        end
                        if (bit_q == '0) begin
                            lrck_d  = slot_q ? LRCK_RIGHT : LRCK_LEFT;
                            sdata_d = 1'b0;
                            if (!slot_q) begin
                                phase_step = 1'b1;
                                strobe_d   = 1'b1;
                            end
                        end else if (bit_q == BIT_ONE) begin
                            sdata_d = hold_q[DATA_W-1];
                            shift_d = hold_q << 1;
                        end else if (bit_q <= DATA_LAST) begin
                            sdata_d = shift_q[DATA_W-1];
                            shift_d = shift_q << 1;
                        end else begin
                            sdata_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset lands everything in IDLE with the idle line levels
    always_ff @(posedge scki or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            slot_q   <= 1'b0;
            lrck_q   <= LRCK_RIGHT;
            sdata_q  <= 1'b0;
            shift_q  <= '0;
            hold_q   <= '0;
            strobe_q <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bck_q    <= bck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            slot_q   <= slot_d;
            lrck_q   <= lrck_d;
            sdata_q  <= sdata_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            cap_q    <= cap_d;
        end
    end

    assign bck          = bck_q;
    assign lrck         = lrck_q;
    assign sdata        = sdata_q;
    assign frame_strobe = strobe_q;
    assign busy         = (state_q == ST_RUN);

endmodule
